leaf_xbar_arbiter: RTL and testbench

- Crossbar scheduler for the leaf router. It arbitrates between 5 input requesters: 0=GPU, 1..4=spine11/21/31/41.
- Each requester targets one output port. The block issues one grant at a time, holds it for a packet burst and drives the crossbar select plus a per-beat pop strobe.
- It replaces the ad-hoc grant logic behind crossbar_busy/current_grant.
- Fixed-priority mode when arb_enable=0; round-robin mode when arb_enable=1.

---
 rtl/leaf_xbar_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_leaf_xbar_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/leaf_xbar_arbiter.sv
// Leaf-router crossbar scheduler: one burst-limited grant at a time, fixed-priority or round-robin.
// Optional stall watchdog is compiled in with `define LEAF_ARB_WATCHDOG_EN.

module leaf_xbar_elig #(
   parameter int NPORT = 5
) (
   input  logic             req,
   input  logic [2:0]       dest,
   input  logic [NPORT-1:0] out_full,
   output logic             eligible,
   output logic             bad_dest
);
   // bad_dest masks the full lookup so an out-of-range index never matters
   assign bad_dest = req & (dest >= 3'(NPORT));
   assign eligible = req & ~bad_dest & ~out_full[dest];
endmodule

module leaf_xbar_arbiter #(
   parameter int NPORT       = 5,
   parameter int MAX_BURST   = 4,
   parameter int STALL_LIMIT = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               arb_enable,
   input  logic [NPORT-1:0]   req,
   input  logic [3*NPORT-1:0] dest_port,
   input  logic [NPORT-1:0]   out_full,
   output logic [NPORT-1:0]   grant,
   output logic [2:0]         grant_id,
   output logic [2:0]         route_sel,
   output logic               xfer_fire,
   output logic               busy,
   output logic               dest_err,
   output logic               timeout
);
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
   localparam logic [2:0] NONE = 3'b111;

   // 3'b111 is reserved for "no grant", so at most 7 requesters
   if (NPORT < 2 || NPORT > 7 || MAX_BURST < 1 || STALL_LIMIT < 1) begin : g_bad_cfg
      $error("leaf_xbar_arbiter: unsupported parameter set");
   end

   typedef enum logic {IDLE, XFER} state_t;
   state_t state_q, state_d;

   logic [NPORT-1:0][2:0] dest;
   logic [NPORT-1:0]      elig, bad;

   for (genvar i = 0; i < NPORT; i++) begin : g_lane
      assign dest[i] = dest_port[3*i +: 3];
      leaf_xbar_elig #(.NPORT(NPORT)) u_elig (
         .req      (req[i]),
         .dest     (dest[i]),
         .out_full (out_full),
         .eligible (elig[i]),
         .bad_dest (bad[i])
      );
   end

   logic [2:0]       rr_ptr, ptr_d;
   logic [BW-1:0]    beat_cnt, beat_d;
   logic [NPORT-1:0] grant_d;
   logic [2:0]       gid_d, route_d;
   logic             busy_d, err_d, rel;

   // winner selection
   logic [2:0] win_fp, win_rr, win, rr_idx;
   logic [3:0] rr_sum;
   logic       rr_hit, any_elig;

   always_comb begin
      win_fp   = '0;
      win_rr   = '0;
      rr_idx   = '0;
      rr_sum   = '0;
      rr_hit   = 1'b0;
      any_elig = |elig;
      for (int k = NPORT - 1; k >= 0; k--)
         if (elig[k]) win_fp = 3'(k);
      for (int k = 0; k < NPORT; k++) begin
         rr_sum = {1'b0, rr_ptr} + 4'(k);
         if (rr_sum >= 4'(NPORT)) rr_sum = rr_sum - 4'(NPORT);
         rr_idx = rr_sum[2:0];
         if (!rr_hit && elig[rr_idx]) begin
            win_rr = rr_idx;
            rr_hit = 1'b1;
         end
      end
      win = arb_enable ? win_rr : win_fp;
   end

   logic g_req, route_full;
   assign g_req      = |(req & grant);
   assign route_full = out_full[route_sel];
   assign xfer_fire  = (state_q == XFER) & g_req & ~route_full;

`ifdef LEAF_ARB_WATCHDOG_EN
   localparam int SW = $clog2(STALL_LIMIT + 1);
   logic [SW-1:0] stall_cnt, stall_d;
   logic          timeout_d;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant;
      gid_d   = grant_id;
      route_d = route_sel;
      busy_d  = busy;
      beat_d  = beat_cnt;
      ptr_d   = rr_ptr;
      err_d   = dest_err | (|bad);
      rel     = 1'b0;
`ifdef LEAF_ARB_WATCHDOG_EN
      stall_d   = stall_cnt;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (any_elig) begin
               state_d = XFER;
               grant_d = NPORT'(1) << win;
               gid_d   = win;
               route_d = dest[win];
               busy_d  = 1'b1;
               beat_d  = '0;
               ptr_d   = (win == 3'(NPORT - 1)) ? 3'd0 : win + 3'd1;
`ifdef LEAF_ARB_WATCHDOG_EN
               stall_d = '0;
`endif
            end
         end
         XFER: begin
            if (xfer_fire) beat_d = beat_cnt + BW'(1);
            if ((xfer_fire && beat_cnt == BEAT_LAST) || !g_req) rel = 1'b1;
`ifdef LEAF_ARB_WATCHDOG_EN
            if (g_req && route_full) begin
               if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
                  rel       = 1'b1;
                  timeout_d = 1'b1;
               end else begin
                  stall_d = stall_cnt + SW'(1);
               end
            end else begin
               stall_d = '0;
            end
`endif
            // clearing beat_cnt on release keeps it from ever wrapping
            if (rel) begin
               state_d = IDLE;
               grant_d = '0;
               gid_d   = NONE;
               busy_d  = 1'b0;
               beat_d  = '0;
`ifdef LEAF_ARB_WATCHDOG_EN
               stall_d = '0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         grant     <= '0;
         grant_id  <= NONE;
         route_sel <= '0;
         busy      <= 1'b0;
         dest_err  <= 1'b0;
         rr_ptr    <= '0;
         beat_cnt  <= '0;
`ifdef LEAF_ARB_WATCHDOG_EN
         stall_cnt <= '0;
         timeout   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant     <= grant_d;
         grant_id  <= gid_d;
         route_sel <= route_d;
         busy      <= busy_d;
         dest_err  <= err_d;
         rr_ptr    <= ptr_d;
         beat_cnt  <= beat_d;
`ifdef LEAF_ARB_WATCHDOG_EN
         stall_cnt <= stall_d;
         timeout   <= timeout_d;
`endif
      end
   end
endmodule

// File: tb/tb_leaf_xbar_arbiter.sv
// Bench for leaf_xbar_arbiter: directed plan steps plus random traffic against a transaction-level model.
// Build with +define+LEAF_ARB_WATCHDOG_EN to cover the stall watchdog.

module tb_leaf_xbar_arbiter;
   localparam int NPORT = 5, MAX_BURST = 4, STALL_LIMIT = 8;

   logic               clk = 1'b0, reset = 1'b1, arb_enable = 1'b0;
   logic [NPORT-1:0]   req = '0, out_full = '0;
   logic [3*NPORT-1:0] dest_port = '0;
   logic [NPORT-1:0]   grant;
   logic [2:0]         grant_id, route_sel;
   logic               xfer_fire, busy, dest_err, timeout;

   leaf_xbar_arbiter #(.NPORT(NPORT), .MAX_BURST(MAX_BURST), .STALL_LIMIT(STALL_LIMIT)) dut (
      .clk(clk), .reset(reset), .arb_enable(arb_enable), .req(req), .dest_port(dest_port),
      .out_full(out_full), .grant(grant), .grant_id(grant_id), .route_sel(route_sel),
      .xfer_fire(xfer_fire), .busy(busy), .dest_err(dest_err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int n_assert = 0, n_fail = 0;

   // model: who holds the crossbar, where it routes, beats moved so far, next RR start
   int m_busy, m_g, m_route, m_done, m_ptr, m_err, m_to, m_stall;
   int fire_cnt, to_cnt, prev_busy;
   int gq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int dst(input int i);
      logic [2:0] d;
      d = dest_port[3*i +: 3];
      return int'(d);
   endfunction

   function automatic bit elig(input int i);
      if (!req[i] || dst(i) >= NPORT) return 1'b0;
      return !out_full[dst(i)];
   endfunction

   task automatic model_reset();
      m_busy = 0; m_g = 0; m_route = 0; m_done = 0; m_ptr = 0;
      m_err = 0; m_to = 0; m_stall = 0; prev_busy = 0;
   endtask

   task automatic model_update();
      int w, i;
      bit fire;
      for (int k = 0; k < NPORT; k++) if (req[k] && dst(k) >= NPORT) m_err = 1;
      m_to = 0;
      if (!m_busy) begin
         w = -1;
         for (int k = 0; k < NPORT; k++) begin
            i = arb_enable ? (m_ptr + k) % NPORT : k;
            if (w < 0 && elig(i)) w = i;
         end
         if (w >= 0) begin
            m_busy = 1; m_g = w; m_route = dst(w); m_done = 0; m_stall = 0;
            m_ptr = (w + 1) % NPORT;
         end
      end else begin
         fire = req[m_g] && !out_full[m_route];
         if (fire) begin m_done++; m_stall = 0; end
         else if (req[m_g]) m_stall++;
         if (!req[m_g] || m_done == MAX_BURST) m_busy = 0;
`ifdef LEAF_ARB_WATCHDOG_EN
         else if (m_stall == STALL_LIMIT) begin m_busy = 0; m_to = 1; end
`endif
      end
   endtask

   // one clock: check every output mid-cycle, then advance the model past the edge
   task automatic cyc();
      @(negedge clk);
      chk("grant", grant, m_busy ? (32'd1 << m_g) : 32'd0);
      chk("grant_id", grant_id, m_busy ? m_g : 7);
      chk("route_sel", route_sel, m_route);
      chk("busy", busy, m_busy);
      chk("xfer_fire", xfer_fire, (m_busy && req[m_g] && !out_full[m_route]) ? 1 : 0);
      chk("dest_err", dest_err, m_err);
      chk("timeout", timeout, m_to);
      if (busy && !prev_busy) gq.push_back(int'(grant_id));
      prev_busy = int'(busy);
      fire_cnt += int'(xfer_fire);
      to_cnt   += int'(timeout);
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic set_dest(input int i, input int v);
      dest_port[3*i +: 3] = 3'(v);
   endtask

   initial begin
      model_reset();
      fire_cnt = 0; to_cnt = 0;
      @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_grant_id", grant_id, 7);
      chk("rst_busy", busy, 0);
      do_reset();
      run(2);

      // single requester: 1-cycle latency, 4 beats, one bubble, re-grant
      set_dest(0, 1); req = 5'b00001; fire_cnt = 0; gq.delete();
      run(6);
      chk("t1_fires", fire_cnt, 4);
      chk("t1_grants", gq.size(), 1);
      run(1);
      chk("t1_regrant", gq.size() == 2 ? gq[1] : 99, 0);
      req = '0; run(2);

      // fixed priority: 1 beats 2, and keeps winning
      set_dest(1, 0); set_dest(2, 0); req = 5'b00110; gq.delete();
      run(12);
      chk("t2_first", gq.size() > 0 ? gq[0] : 99, 1);
      chk("t2_second", gq.size() > 1 ? gq[1] : 99, 1);
      req = '0; run(2);

      // round-robin from pointer 0
      do_reset();
      arb_enable = 1'b1; set_dest(0, 0); req = 5'b00111; gq.delete();
      run(20);
      chk("t3_n", gq.size(), 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("t3_order%0d", k), gq.size() > k ? gq[k] : 99, (k == 3) ? 0 : k);
      req = '0; arb_enable = 1'b0; run(2);

      // stall 3 cycles mid-burst
      do_reset();
      set_dest(0, 2); req = 5'b00001; fire_cnt = 0;
      run(3);
      out_full[2] = 1'b1; run(3);
      out_full[2] = 1'b0; run(3);
      chk("t4_fires", fire_cnt, 4);
      req = '0; run(2);

      // bad destination, then full-blocked requester
      do_reset();
      set_dest(3, 6); req = 5'b01000; gq.delete();
      run(4);
      chk("t5_err", dest_err, 1);
      set_dest(2, 1); out_full = 5'b00010; req = 5'b01100;
      run(4);
      chk("t5_none", gq.size(), 0);
      out_full = '0; run(2);
      chk("t5_g2", gq.size() == 1 ? gq[0] : 99, 2);
      req = '0; run(4);

      // asynchronous reset after 2 beats
      do_reset();
      set_dest(0, 1); req = 5'b00001;
      run(3);
      #2 reset = 1'b1;
      #1;
      chk("t6_grant", grant, 0);
      chk("t6_gid", grant_id, 7);
      chk("t6_busy", busy, 0);
      req = '0;
      do_reset();
      run(1);

      // persistent stall: watchdog releases it, or the grant is held
      set_dest(0, 1); req = 5'b00001; to_cnt = 0; gq.delete();
      run(1);
      out_full[1] = 1'b1;
      run(10);
`ifdef LEAF_ARB_WATCHDOG_EN
      chk("t7_timeout", to_cnt, 1);
      chk("t7_released", busy, 0);
`else
      chk("t7_timeout", to_cnt, 0);
      chk("t7_held", busy, 1);
`endif
      out_full = '0; req = '0; run(2);

      // random traffic
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NPORT; i++) begin
            req[i]      = ($urandom_range(0, 2) != 0);
            out_full[i] = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0)
               set_dest(i, ($urandom_range(0, 19) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4)));
         end
         if ($urandom_range(0, 9) == 0) arb_enable = ~arb_enable;
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
